// File: rtl/dma_pkg.sv
// dma_pkg: shared constants for the bus DMA master.
//   - FSM state encodings (kept as plain localparams for legacy tool compatibility)
//   - word step used for address advance
//   - base of the peripheral window, shared with the CPU-side decode
package dma_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRd   = 2'd1;
  localparam logic [1:0] StWr   = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam int unsigned WordStep = 4;

  localparam logic [31:0] PeriphBase = 32'h4000_0000;

endpackage

// File: rtl/dma_addr_gen.sv
// dma_addr_gen: source/destination address and remaining-length counters for the DMA.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   load           latch src/dst (word-aligned) and len
//   step           advance both addresses by one word and decrement remain
//   src, dst, len  values latched on load
//   cur_src        current read address
//   cur_dst        current write address
//   last           remain == 1 (the word in flight is the final one)
module dma_addr_gen #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] cur_src,
  output logic [ADDR_W-1:0] cur_dst,
  output logic              last
);
  import dma_pkg::*;

  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  remain_q;

  // Address arithmetic wraps modulo 2^ADDR_W by construction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q    <= '0;
      dst_q    <= '0;
      remain_q <= '0;
    end else if (load) begin
      src_q    <= {src[ADDR_W-1:2], 2'b00};
      dst_q    <= {dst[ADDR_W-1:2], 2'b00};
      remain_q <= len;
    end else if (step) begin
      src_q    <= src_q + ADDR_W'(WordStep);
      dst_q    <= dst_q + ADDR_W'(WordStep);
      remain_q <= remain_q - LEN_W'(1);
    end
  end

  assign cur_src = src_q;
  assign cur_dst = dst_q;
  assign last    = (remain_q == LEN_W'(1));

endmodule

// File: rtl/bus_dma_master.sv
// bus_dma_master: bus initiator copying a block of 32-bit words from src to dst over the
// CPU data bus. Reads return combinationally; responders commit writes on the negedge.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   start              1-cycle pulse: latch src/dst/len and begin (ignored while busy)
//   abort              stop at next posedge (RD/WR only)
//   src, dst, len      block source, destination (word-aligned internally), word count
//   busy, done         transfer active; 1-cycle completion/abort pulse
//   bus_req, bus_gnt   arbiter handshake
//   rd, wr, addr       bus strobes and address, driven only while granted
//   wdata, rdata       bus write / read data
//   irq, irq_ack       sticky completion interrupt and its clear (only with DMA_IRQ_EN)
// Configuration: define DMA_IRQ_EN to add the irq/irq_ack ports.
module bus_dma_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              rd,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic [31:0]       rdata
`ifdef DMA_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_ack
`endif
);
  import dma_pkg::*;

  logic [1:0]        state_q, state_d;
  logic [31:0]       data_buf_q;
  logic              load, step, capture, last;
  logic [ADDR_W-1:0] cur_src, cur_dst;

  dma_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .src     (src),
    .dst     (dst),
    .len     (len),
    .cur_src (cur_src),
    .cur_dst (cur_dst),
    .last    (last)
  );

  // Priority in RD/WR: abort, then grant stall, then advance.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          state_d = (len == '0) ? StDone : StRd;
        end
      end
      StRd: begin
        if (abort) begin
          state_d = StDone;
        end else if (bus_gnt) begin
          capture = 1'b1;
          state_d = StWr;
        end
      end
      StWr: begin
        if (abort) begin
          state_d = StDone;
        end else if (bus_gnt) begin
          step    = 1'b1;
          state_d = last ? StDone : StRd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      data_buf_q <= '0;
    end else begin
      state_q <= state_d;
      // Buffer survives a grant withdrawal between RD and WR, so no re-read is needed.
      if (capture) data_buf_q <= rdata;
    end
  end

  always_comb begin
    rd    = bus_gnt && (state_q == StRd);
    wr    = bus_gnt && (state_q == StWr);
    addr  = rd ? cur_src : (wr ? cur_dst : '0);
    wdata = wr ? data_buf_q : '0;
  end

  assign busy    = (state_q != StIdle);
  assign bus_req = busy;
  assign done    = (state_q == StDone);

`ifdef DMA_IRQ_EN
  logic irq_q;
  // Set covers both the edge entering DONE and the DONE cycle, so an ack coincident with
  // done cannot clear it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else if ((state_d == StDone) || done) begin
      irq_q <= 1'b1;
    end else if (irq_ack) begin
      irq_q <= 1'b0;
    end
  end
  assign irq = irq_q;
`endif

endmodule
